// File: rtl/profile_ci_reader.sv
// Custom-instruction event-counter block: start/stop/clear counters and read
// them (or their sticky overflow flags) back over a two-cycle CI handshake.
module profile_ci_reader #(
    parameter logic [7:0] CUSTOM_ID      = 8'd12,
    parameter int         NR_OF_COUNTERS = 4,
    parameter int         WIDTH          = 32
) (
    input  logic                      clock,
    input  logic                      nReset,
    input  logic                      ciStart,
    input  logic                      ciCke,
    input  logic [7:0]                ciN,
    input  logic [31:0]               ciValueA,
    input  logic [31:0]               ciValueB,
    input  logic [NR_OF_COUNTERS-1:0] eventIn,
    output logic                      ciDone,
    output logic [31:0]               ciResult
);

    localparam int NR = NR_OF_COUNTERS;

    typedef enum logic {
        IDLE,
        RESPOND
    } state_t;

    state_t                  state_q, state_d;
    logic [NR-1:0][WIDTH-1:0] cnt_q, cnt_d;
    logic [NR-1:0]           en_q, en_d;
    logic [NR-1:0]           ovf_q, ovf_d;
    logic                    done_q, done_d;
    logic [31:0]             result_q, result_d;

    logic                    accept;
    logic [NR-1:0]           start_m;
    logic [NR-1:0]           stop_m;
    logic [NR-1:0]           clear_m;
    logic [31:0]             snapshot;
    logic                    unused_bits;

    assign accept  = ciStart & ciCke & (ciN == CUSTOM_ID);
    assign start_m = ciValueB[NR-1:0];
    assign stop_m  = ciValueB[2*NR-1:NR];
    assign clear_m = ciValueB[3*NR-1:2*NR];

    // Only parts of the operand words carry meaning.
    assign unused_bits = ^{ciValueA, ciValueB};

    // Read data from pre-update state; out-of-range index reads zero.
    always_comb begin
        snapshot = '0;
        if (ciValueA[31]) begin
            snapshot[NR-1:0] = ovf_q;
        end else begin
            for (int i = 0; i < NR; i++) begin
                if (ciValueA[3:0] == 4'(i)) begin
                    snapshot[WIDTH-1:0] = cnt_q[i];
                end
            end
        end
    end

    // Counter, enable and overflow next state; clear beats stop beats start.
    always_comb begin
        cnt_d = cnt_q;
        en_d  = en_q;
        ovf_d = ovf_q;
        if (ciCke) begin
            for (int i = 0; i < NR; i++) begin
                if (accept && clear_m[i]) begin
                    cnt_d[i] = '0;
                    ovf_d[i] = 1'b0;
                end else begin
                    if (en_q[i] && eventIn[i]) begin
                        cnt_d[i] = cnt_q[i] + WIDTH'(1);
                        if (&cnt_q[i]) begin
                            ovf_d[i] = 1'b1;
                        end
                    end
                    if (accept && stop_m[i]) begin
                        en_d[i] = 1'b0;
                    end else if (accept && start_m[i]) begin
                        en_d[i] = 1'b1;
                    end
                end
            end
        end
    end

    // Handshake FSM next state: respond one enabled cycle after accept.
    always_comb begin
        state_d  = state_q;
        done_d   = done_q;
        result_d = result_q;
        if (ciCke) begin
            if (accept) begin
                state_d  = RESPOND;
                done_d   = 1'b1;
                result_d = snapshot;
            end else begin
                state_d  = IDLE;
                done_d   = 1'b0;
                result_d = '0;
            end
        end
    end

    // All state registers with asynchronous clear.
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            en_q     <= '0;
            ovf_q    <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            en_q     <= en_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign ciDone   = done_q;
    assign ciResult = result_q;

endmodule
